// File: rtl/pipe_mips32_loader_pkg.sv
// Shared definitions for the MIPS32 program loader, the CPU and the bench:
// loader state encoding, default geometry and the instruction opcodes.
package pipe_mips32_loader_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int MAX_WORDS_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_START = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ldr_state_e;

    // MIPS32 subset opcodes, instr[31:26].
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/pipe_mips32_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader is the slave of the byte stream and drives the memory port.
interface pipe_mips32_loader_if
    import pipe_mips32_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/pipe_mips32_word_asm.sv
// Big-endian byte-to-word assembler. word_valid is combinational and marks
// the cycle in which the fourth byte of a word is accepted; word then holds
// the three stored bytes followed by the byte on in_data.
module pipe_mips32_word_asm (
    input  logic        clk1,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic        accept;

    assign in_ready   = enable;
    assign accept     = in_valid & enable;
    assign word       = {shift_q, in_data};
    assign word_valid = accept & (byte_cnt_q == 2'd3);

    // Byte counter (wraps 3->0 on a completed word) and partial-word shifter;
    // both hold their value while no byte is accepted.
    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || clear) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {shift_q[15:0], in_data};
        end
    end

endmodule

// File: rtl/pipe_mips32_loader.sv
// MIPS32 instruction-memory loader: receives header N, N program words and a
// checksum over a byte stream, writes the program words to addresses 0..N-1
// and pulses cpu_start when the checksum matches.
module pipe_mips32_loader
    import pipe_mips32_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic                  clk1,
    input  logic                  reset,
    input  logic                  load_go,
    pipe_mips32_loader_if.slave   bus,
    output logic                  cpu_start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W:0]       words_loaded
);

    ldr_state_e        state_q, state_d;

    logic [31:0]       word;
    logic              word_valid;
    logic              asm_ready;
    logic              stream_en;
    logic              start_load;
    logic              hdr_bad;
    logic              last_word;
    logic [ADDR_W:0]   wl_inc;

    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic [31:0]       sum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    assign stream_en  = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CKSUM);
    assign start_load = load_go &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdr_bad    = (word == 32'd0) || (word > 32'(MAX_WORDS));
    assign wl_inc     = words_loaded_q + (ADDR_W+1)'(1);
    assign last_word  = (wl_inc == n_q);

    pipe_mips32_word_asm u_word_asm (
        .clk1       (clk1),
        .reset      (reset),
        .clear      (start_load),
        .enable     (stream_en),
        .in_valid   (bus.in_valid),
        .in_data    (bus.in_data),
        .in_ready   (asm_ready),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk1) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; stream words only advance the FSM when complete.
    always_comb begin
        // NOTE: assign the default first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (load_go) state_d = ST_HDR;
            ST_HDR:   if (word_valid) state_d = hdr_bad ? ST_ERR : ST_LOAD;
            ST_LOAD:  if (word_valid && last_word) state_d = ST_CKSUM;
            ST_CKSUM: if (word_valid) state_d = (word == sum_q) ? ST_START : ST_ERR;
            ST_START: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch N, issue one write per program word, keep the running sum.
    always_ff @(posedge clk1) begin
        if (reset) begin
            n_q            <= '0;
            words_loaded_q <= '0;
            sum_q          <= 32'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (start_load) begin
                words_loaded_q <= '0;
                sum_q          <= 32'd0;
            end
            if ((state_q == ST_HDR) && word_valid && !hdr_bad) begin
                n_q <= word[ADDR_W:0];
            end
            if ((state_q == ST_LOAD) && word_valid) begin
                mem_we_q       <= 1'b1;
                mem_addr_q     <= words_loaded_q[ADDR_W-1:0];
                mem_wdata_q    <= word;
                words_loaded_q <= wl_inc;
                sum_q          <= sum_q + word;
            end
        end
    end

    assign bus.in_ready  = asm_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign cpu_start     = (state_q == ST_START);
    assign busy          = stream_en;
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign words_loaded  = words_loaded_q;

endmodule
